sync_filter: RTL and testbench

- Multi-channel level synchroniser with per-channel glitch filter and edge-pulse generation.
- Each channel first passes through a Stages-deep metastability chain. It then passes through a counter-based debounce filter that accepts a new level only after it has been stable for FilterCycles consecutive clocks.
- Used on asynchronous pads and cross-domain status lines: GPIO inputs, interrupt lines, external strap/ready signals.
- Generalises the two-flop synchroniser cell to many channels, adds per-channel reset values, filtering and rise/fall pulses.

---
 rtl/sync_filter_pkg.sv | 18 +
 rtl/sync_filter_cell.sv | 36 +++
 rtl/sync_filter_chan.sv | 85 ++++++++
 rtl/sync_filter.sv | 51 +++++
 tb/tb_sync_filter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_filter_pkg.sv
// Shared helpers for the sync_filter block.
// Holds the default parameter values and the counter-width helper
// used by the per-channel filter.
package sync_filter_pkg;

  localparam int unsigned DefaultNumChannels  = 8;
  localparam int unsigned DefaultStages       = 2;
  localparam int unsigned DefaultFilterCycles = 4;

  // Width of a counter that must hold values 0 .. filter_cycles.
  function automatic int unsigned cnt_width(input int unsigned filter_cycles);
    if (filter_cycles < 1) begin
      return 1;
    end
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_cell.sv
// Common single-bit synchroniser cell: a Stages-deep flop chain that moves
// an asynchronous level into the clk_i domain.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, chain loads ResetValue
//   d_i    - asynchronous input level
//   q_o    - synchronised level (last chain stage)
module sync_filter_cell #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (Stages < 2) begin : g_param_check
    $error("sync_filter_cell: Stages must be >= 2");
  end

  // Metastability chain; kept intact and placed together by implementation tools.
  (* async_reg = "true", dont_touch = "true" *)
  logic [Stages-1:0] chain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain <= {Stages{ResetValue}};
    end else begin
      chain <= {chain[Stages-2:0], d_i};
    end
  end

  assign q_o = chain[Stages-1];

endmodule

// File: rtl/sync_filter_chan.sv
// One channel of sync_filter: synchroniser, counter-based debounce filter
// and registered rise/fall edge pulses.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   serial_i - asynchronous raw input
//   serial_o - synchronised, filtered level
//   rise_o   - one-cycle pulse on the cycle serial_o first shows 1
//   fall_o   - one-cycle pulse on the cycle serial_o first shows 0
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int unsigned Stages       = DefaultStages,
  parameter int unsigned FilterCycles = DefaultFilterCycles,
  parameter logic        ResetValue   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_width(FilterCycles);
  // Last count value before a mismatch is accepted; the counter never passes it.
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  if (FilterCycles < 1) begin : g_param_check
    $error("sync_filter_chan: FilterCycles must be >= 1");
  end

  logic            sync_level;
  logic            level;
  logic            level_next;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_next;
  logic            rise_next;
  logic            fall_next;

  sync_filter_cell #(
    .Stages     (Stages),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (serial_i),
    .q_o    (sync_level)
  );

  // Debounce: count consecutive mismatching samples, accept on the last one.
  always_comb begin
    cnt_next   = '0;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (sync_level != level) begin
      if (cnt == CntLast) begin
        level_next = sync_level;
        rise_next  = sync_level;
        fall_next  = ~sync_level;
      end else begin
        cnt_next = CntW'(cnt + CntW'(1));
      end
    end
  end

  // Filter state and edge pulses; pulses coincide with the level update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      level  <= ResetValue;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      level  <= level_next;
      rise_o <= rise_next;
      fall_o <= fall_next;
    end
  end

  assign serial_o = level;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel level synchroniser with per-channel glitch filter and
// rise/fall pulse generation. Channels are fully independent.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   serial_i - [NumChannels] asynchronous raw inputs
//   serial_o - [NumChannels] synchronised, filtered levels
//   rise_o   - [NumChannels] one-cycle pulse when serial_o[c] goes 0->1
//   fall_o   - [NumChannels] one-cycle pulse when serial_o[c] goes 1->0
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int unsigned            NumChannels  = DefaultNumChannels,
  parameter int unsigned            Stages       = DefaultStages,
  parameter int unsigned            FilterCycles = DefaultFilterCycles,
  parameter logic [NumChannels-1:0] ResetValue   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] serial_i,
  output logic [NumChannels-1:0] serial_o,
  output logic [NumChannels-1:0] rise_o,
  output logic [NumChannels-1:0] fall_o
);

  if (NumChannels < 1) begin : g_chan_check
    $error("sync_filter: NumChannels must be >= 1");
  end
  if (Stages < 2) begin : g_stage_check
    $error("sync_filter: Stages must be >= 2");
  end
  if (FilterCycles < 1) begin : g_filter_check
    $error("sync_filter: FilterCycles must be >= 1");
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    sync_filter_chan #(
      .Stages       (Stages),
      .FilterCycles (FilterCycles),
      .ResetValue   (ResetValue[c])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (serial_i[c]),
      .serial_o (serial_o[c]),
      .rise_o   (rise_o[c]),
      .fall_o   (fall_o[c])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: two instances (FilterCycles 3 and 1) share stimulus.
// A window-based reference model pushes expected outputs per clock edge;
// a monitor pops and compares on each falling edge.
module tb_sync_filter;

  localparam int unsigned NCH    = 4;
  localparam int unsigned STAGES = 2;
  localparam logic [3:0]  RV     = 4'b0101;

  typedef struct packed {
    logic [3:0] ser;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] serial_i;
  logic [3:0] ser3, rise3, fall3;
  logic [3:0] ser1, rise1, fall1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state per instance: raw input pipeline, history of synchronised
  // samples, and the current accepted level.
  logic [3:0] ins_h [2][$];
  logic [3:0] s_h   [2][$];
  logic [3:0] y_m   [2];
  exp_t       exp_q [2][$];

  always #5 clk = ~clk;

  sync_filter #(
    .NumChannels (NCH), .Stages (STAGES), .FilterCycles (3), .ResetValue (RV)
  ) dut3 (
    .clk_i (clk), .rst_ni (rst_n), .serial_i (serial_i),
    .serial_o (ser3), .rise_o (rise3), .fall_o (fall3)
  );

  sync_filter #(
    .NumChannels (NCH), .Stages (STAGES), .FilterCycles (1), .ResetValue (RV)
  ) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .serial_i (serial_i),
    .serial_o (ser1), .rise_o (rise1), .fall_o (fall1)
  );

  function automatic int fc_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.ser  = RV;
    e.rise = '0;
    e.fall = '0;
    return e;
  endfunction

  function automatic void model_reset(input int i);
    ins_h[i].delete();
    s_h[i].delete();
    for (int k = 0; k < int'(STAGES); k++) ins_h[i].push_back(RV);
    y_m[i] = RV;
  endfunction

  // A level is accepted when the last fc synchronised samples all differ
  // from the currently accepted level.
  function automatic exp_t model_edge(input int i, input logic [3:0] din);
    exp_t       e;
    logic [3:0] s;
    logic [3:0] h;
    logic       all_diff;
    int         fc;
    fc = fc_of(i);
    s  = ins_h[i].pop_front();
    ins_h[i].push_back(din);
    s_h[i].push_back(s);
    if (s_h[i].size() > fc) void'(s_h[i].pop_front());
    e.rise = '0;
    e.fall = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      all_diff = (s_h[i].size() == fc);
      for (int j = 0; j < s_h[i].size(); j++) begin
        h = s_h[i][j];
        if (h[c] == y_m[i][c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        y_m[i][c] = ~y_m[i][c];
        e.rise[c] = y_m[i][c];
        e.fall[c] = ~y_m[i][c];
      end
    end
    e.ser = y_m[i];
    return e;
  endfunction

  // Model: one expected entry per rising edge; reset flushes partial history.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          model_reset(i);
          exp_q[i].delete();
          exp_q[i].push_back(reset_exp());
        end else begin
          exp_q[i].push_back(model_edge(i, serial_i));
        end
      end
    end
  end

  // Monitor: compares both instances on every falling edge.
  initial begin
    exp_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        act = (i == 0) ? {ser3, rise3, fall3} : {ser1, rise1, fall1};
        vectors++;
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
        end else if (!rst_n) begin
          e = reset_exp();
        end else begin
          miscompares++;
          $display("FAIL underflow fc%0d at %0t: no expected entry", fc_of(i), $time);
          continue;
        end
        if (act !== e) begin
          miscompares++;
          $display("FAIL outputs fc%0d at %0t: got ser=%b rise=%b fall=%b, expected ser=%b rise=%b fall=%b",
                   fc_of(i), $time, act.ser, act.rise, act.fall, e.ser, e.rise, e.fall);
        end
      end
    end
  end

  // Drive inputs and reset 2 time units after a rising edge.
  task automatic step(input logic [3:0] v, input logic r);
    @(posedge clk);
    #2;
    serial_i = v;
    rst_n    = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(serial_i, rst_n);
  endtask

  initial begin
    logic [3:0] cur;
    rst_n    = 1'b0;
    serial_i = 4'b1010;

    // Reset held with inputs opposite to the reset value.
    repeat (4) step(4'b1010, 1'b0);
    cur = RV;
    step(cur, 1'b1);
    idle(4);

    // Single step on channel 1.
    cur[1] = 1'b1;
    step(cur, 1'b1);
    idle(8);

    // Glitches on channel 0: 2 cycles (rejected), then 3 cycles (accepted).
    cur[0] = 1'b0; step(cur, 1'b1); idle(1);
    cur[0] = 1'b1; step(cur, 1'b1); idle(6);
    cur[0] = 1'b0; step(cur, 1'b1); idle(2);
    cur[0] = 1'b1; step(cur, 1'b1); idle(8);

    // Chatter on channel 2.
    for (int k = 0; k < 50; k++) begin
      cur[2] = ~cur[2];
      step(cur, 1'b1);
    end
    cur = RV;
    step(cur, 1'b1);
    idle(8);

    // All channels flip together.
    cur = 4'b1010;
    step(cur, 1'b1);
    idle(8);

    // Asynchronous reset asserted mid-cycle while running.
    step(cur, 1'b0);
    idle(2);
    cur = RV;
    step(cur, 1'b1);
    idle(6);

    // Reset after 2 of 3 stable samples, released with input at reset value.
    cur[3] = ~cur[3];
    step(cur, 1'b1);
    idle(STAGES + 1);
    cur = RV;
    step(cur, 1'b0);
    idle(2);
    step(cur, 1'b1);
    idle(8);

    // Random: each bit flips with probability 1/4 per cycle.
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
      end
      step(cur, 1'b1);
    end
    // Random with longer holds.
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
      end
      step(cur, 1'b1);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
